// File: rtl/frame_channel_sequencer.sv
// frame_channel_sequencer: drives one subframe decoder across every channel of a
// FLAC frame, tagging each decoded sample with its channel and index and
// reporting frame completion or error.
module frame_channel_sequencer #(
  parameter int unsigned WATCHDOG_CYCLES = 4096,
  parameter int unsigned RESET_CYCLES    = 2
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iFrameStart,
  input  logic [15:0]        iBlockSize,
  input  logic [2:0]         iChannelCount,
  input  logic               iReady,
  output logic               oDecReset,
  output logic               oDecEnable,
  output logic [15:0]        oDecBlockSize,
  input  logic               iDecSampleValid,
  input  logic signed [15:0] iDecSample,
  input  logic               iDecFrameDone,
  output logic               oSampleValid,
  output logic signed [15:0] oSample,
  output logic [2:0]         oChannel,
  output logic [15:0]        oSampleIndex,
  output logic               oBusy,
  output logic               oFrameDone,
  output logic               oError,
  output logic [1:0]         oErrorCode
);

  localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam int unsigned RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

  localparam logic [1:0] ERR_SHORT    = 2'd1;
  localparam logic [1:0] ERR_WATCHDOG = 2'd2;
  localparam logic [1:0] ERR_ZERO_BS  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    DEC_RESET,
    RUN,
    NEXT_CH,
    DONE,
    ERROR
  } state_t;

  state_t state, state_nxt;

  logic [15:0]     block_size;
  logic [2:0]      ch_last;
  logic [2:0]      channel;
  logic [15:0]     sample_cnt;
  logic [15:0]     cnt_inc;
  logic [WD_W-1:0] wdog_cnt;
  logic [RC_W-1:0] rst_cnt;
  logic            start;
  logic            accept;
  logic            err_set;
  logic [1:0]      err_code_nxt;

  assign oDecBlockSize = block_size;

  // Next-state decode and decoder control outputs.
  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    accept       = 1'b0;
    err_set      = 1'b0;
    err_code_nxt = '0;
    oDecReset    = 1'b0;
    oDecEnable   = 1'b0;
    oFrameDone   = 1'b0;
    oBusy        = (state != IDLE);
    cnt_inc      = sample_cnt + 16'd1;

    case (state)
      IDLE, ERROR: begin
        oDecReset = 1'b1;
        if (iFrameStart) begin
          start = 1'b1;
          if (iBlockSize == '0) begin
            state_nxt    = ERROR;
            err_set      = 1'b1;
            err_code_nxt = ERR_ZERO_BS;
          end else begin
            state_nxt = DEC_RESET;
          end
        end
      end
      DEC_RESET: begin
        oDecReset = 1'b1;
        if (rst_cnt == RC_LAST) state_nxt = RUN;
      end
      RUN: begin
        oDecEnable = iReady;
        accept     = iReady & iDecSampleValid;
        // The completing sample wins over a same-cycle end-of-subframe flag.
        if (accept && (cnt_inc == block_size)) begin
          state_nxt = NEXT_CH;
        end else if (iDecFrameDone) begin
          state_nxt    = ERROR;
          err_set      = 1'b1;
          err_code_nxt = ERR_SHORT;
        end else if (iReady && !iDecSampleValid && (wdog_cnt == WD_LAST)) begin
          state_nxt    = ERROR;
          err_set      = 1'b1;
          err_code_nxt = ERR_WATCHDOG;
        end
      end
      NEXT_CH: begin
        state_nxt = (channel == ch_last) ? DONE : DEC_RESET;
      end
      DONE: begin
        oFrameDone = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iClock) begin
    if (iReset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Frame parameters, counters, sample output stage and error flags.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      block_size   <= '0;
      ch_last      <= '0;
      channel      <= '0;
      sample_cnt   <= '0;
      wdog_cnt     <= '0;
      rst_cnt      <= '0;
      oSampleValid <= 1'b0;
      oSample      <= '0;
      oChannel     <= '0;
      oSampleIndex <= '0;
      oError       <= 1'b0;
      oErrorCode   <= '0;
    end else begin
      oSampleValid <= accept;
      if (accept) begin
        oSample      <= iDecSample;
        oChannel     <= channel;
        oSampleIndex <= sample_cnt;
        sample_cnt   <= cnt_inc;
      end

      if (state == DEC_RESET) begin
        rst_cnt    <= rst_cnt + 1'b1;
        sample_cnt <= '0;
        wdog_cnt   <= '0;
      end else begin
        rst_cnt <= '0;
      end

      if (state == RUN) begin
        if (accept)      wdog_cnt <= '0;
        else if (iReady) wdog_cnt <= wdog_cnt + 1'b1;
      end

      if ((state == NEXT_CH) && (channel != ch_last)) channel <= channel + 1'b1;

      if (start) begin
        block_size <= iBlockSize;
        ch_last    <= iChannelCount;
        channel    <= '0;
        oError     <= 1'b0;
        oErrorCode <= '0;
      end

      // Placed after the start clear so a zero block size still flags.
      if (err_set) begin
        oError     <= 1'b1;
        oErrorCode <= err_code_nxt;
      end
    end
  end

endmodule

// File: tb/tb_frame_channel_sequencer.sv
// Directed self-checking bench for frame_channel_sequencer.
module tb_frame_channel_sequencer;

  logic               iClock = 1'b0;
  logic               iReset;
  logic               iFrameStart;
  logic [15:0]        iBlockSize;
  logic [2:0]         iChannelCount;
  logic               iReady;
  logic               oDecReset;
  logic               oDecEnable;
  logic [15:0]        oDecBlockSize;
  logic               iDecSampleValid;
  logic signed [15:0] iDecSample;
  logic               iDecFrameDone;
  logic               oSampleValid;
  logic signed [15:0] oSample;
  logic [2:0]         oChannel;
  logic [15:0]        oSampleIndex;
  logic               oBusy;
  logic               oFrameDone;
  logic               oError;
  logic [1:0]         oErrorCode;

  int checks   = 0;
  int failures = 0;

  always #5 iClock = ~iClock;

  frame_channel_sequencer #(
    .WATCHDOG_CYCLES(16),
    .RESET_CYCLES   (2)
  ) dut (
    .iClock         (iClock),
    .iReset         (iReset),
    .iFrameStart    (iFrameStart),
    .iBlockSize     (iBlockSize),
    .iChannelCount  (iChannelCount),
    .iReady         (iReady),
    .oDecReset      (oDecReset),
    .oDecEnable     (oDecEnable),
    .oDecBlockSize  (oDecBlockSize),
    .iDecSampleValid(iDecSampleValid),
    .iDecSample     (iDecSample),
    .iDecFrameDone  (iDecFrameDone),
    .oSampleValid   (oSampleValid),
    .oSample        (oSample),
    .oChannel       (oChannel),
    .oSampleIndex   (oSampleIndex),
    .oBusy          (oBusy),
    .oFrameDone     (oFrameDone),
    .oError         (oError),
    .oErrorCode     (oErrorCode)
  );

  task automatic tick;
    @(posedge iClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse a frame start and walk through the two decoder-reset cycles into RUN.
  task automatic enter_run(input logic [15:0] bs, input logic [2:0] cc);
    iBlockSize    = bs;
    iChannelCount = cc;
    iFrameStart   = 1'b1;
    tick();
    iFrameStart = 1'b0;
    chk("start_busy", 16'(oBusy), 16'd1);
    chk("start_decreset1", 16'(oDecReset), 16'd1);
    chk("start_blocksize", oDecBlockSize, bs);
    chk("start_err_clear", 16'(oError), 16'd0);
    chk("start_code_clear", 16'(oErrorCode), 16'd0);
    tick();
    chk("start_decreset2", 16'(oDecReset), 16'd1);
    chk("start_enable_off", 16'(oDecEnable), 16'd0);
    tick();
    chk("run_decreset_off", 16'(oDecReset), 16'd0);
    chk("run_enable", 16'(oDecEnable), 16'(iReady));
  endtask

  // Present one decoder sample for one cycle and check the registered output.
  task automatic send(input logic [15:0] smp, input logic [2:0] ch, input logic [15:0] idx);
    iDecSampleValid = 1'b1;
    iDecSample      = smp;
    tick();
    iDecSampleValid = 1'b0;
    chk("smp_valid", 16'(oSampleValid), 16'd1);
    chk("smp_value", oSample, smp);
    chk("smp_channel", 16'(oChannel), 16'(ch));
    chk("smp_index", oSampleIndex, idx);
  endtask

  initial begin
    iReset          = 1'b1;
    iFrameStart     = 1'b0;
    iBlockSize      = '0;
    iChannelCount   = '0;
    iReady          = 1'b0;
    iDecSampleValid = 1'b0;
    iDecSample      = '0;
    iDecFrameDone   = 1'b0;
    tick();
    tick();
    iReset = 1'b0;

    // Reset values
    chk("rst_decreset", 16'(oDecReset), 16'd1);
    chk("rst_enable", 16'(oDecEnable), 16'd0);
    chk("rst_valid", 16'(oSampleValid), 16'd0);
    chk("rst_busy", 16'(oBusy), 16'd0);
    chk("rst_done", 16'(oFrameDone), 16'd0);
    chk("rst_error", 16'(oError), 16'd0);
    chk("rst_code", 16'(oErrorCode), 16'd0);
    chk("rst_blocksize", oDecBlockSize, 16'd0);

    // Mono frame, 4 samples
    iReady = 1'b1;
    enter_run(16'd4, 3'd0);
    for (int i = 0; i < 4; i++) send(16'(i * 37 - 50), 3'd0, 16'(i));
    chk("mono_nextch_enable", 16'(oDecEnable), 16'd0);
    chk("mono_nextch_done", 16'(oFrameDone), 16'd0);
    tick();
    chk("mono_done", 16'(oFrameDone), 16'd1);
    chk("mono_done_novalid", 16'(oSampleValid), 16'd0);
    tick();
    chk("mono_done_single", 16'(oFrameDone), 16'd0);
    chk("mono_idle_busy", 16'(oBusy), 16'd0);
    chk("mono_no_error", 16'(oError), 16'd0);

    // Stereo frame, 3 samples per channel; a mid-run start must be ignored
    enter_run(16'd3, 3'd1);
    iFrameStart = 1'b1;
    iBlockSize  = 16'd9;
    send(16'd200, 3'd0, 16'd0);
    iFrameStart = 1'b0;
    chk("stereo_start_ignored", oDecBlockSize, 16'd3);
    send(16'd201, 3'd0, 16'd1);
    send(16'd202, 3'd0, 16'd2);
    chk("stereo_gap_enable0", 16'(oDecEnable), 16'd0);
    tick();
    chk("stereo_gap_decreset1", 16'(oDecReset), 16'd1);
    chk("stereo_gap_enable1", 16'(oDecEnable), 16'd0);
    tick();
    chk("stereo_gap_decreset2", 16'(oDecReset), 16'd1);
    tick();
    chk("stereo_ch1_decreset", 16'(oDecReset), 16'd0);
    chk("stereo_ch1_enable", 16'(oDecEnable), 16'd1);
    for (int i = 0; i < 3; i++) send(16'(-300 - i), 3'd1, 16'(i));
    chk("stereo_nextch_done", 16'(oFrameDone), 16'd0);
    tick();
    chk("stereo_done", 16'(oFrameDone), 16'd1);
    tick();
    chk("stereo_idle", 16'(oBusy), 16'd0);

    // Backpressure: long ready-low stretch freezes the watchdog, then toggling
    enter_run(16'd4, 3'd0);
    iReady = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("bp_enable_low", 16'(oDecEnable), 16'd0);
      tick();
    end
    chk("bp_frozen_no_error", 16'(oError), 16'd0);
    chk("bp_still_busy", 16'(oBusy), 16'd1);
    for (int k = 0; k < 8; k++) begin
      iReady          = ((k % 2) == 0);
      iDecSampleValid = iReady;
      iDecSample      = 16'(k * 11);
      #1;
      chk("bp_enable_mirror", 16'(oDecEnable), 16'(iReady));
      tick();
      if ((k % 2) == 0) begin
        chk("bp_valid", 16'(oSampleValid), 16'd1);
        chk("bp_index", oSampleIndex, 16'(k / 2));
        chk("bp_value", oSample, 16'(k * 11));
      end else begin
        chk("bp_novalid", 16'(oSampleValid), 16'd0);
      end
    end
    iDecSampleValid = 1'b0;
    chk("bp_done", 16'(oFrameDone), 16'd1);
    chk("bp_no_error", 16'(oError), 16'd0);
    tick();

    // Short subframe: end-of-subframe after 5 of 8 samples
    iReady = 1'b1;
    enter_run(16'd8, 3'd0);
    for (int i = 0; i < 5; i++) send(16'(i + 1), 3'd0, 16'(i));
    iDecFrameDone = 1'b1;
    tick();
    iDecFrameDone = 1'b0;
    chk("short_error", 16'(oError), 16'd1);
    chk("short_code", 16'(oErrorCode), 16'd1);
    chk("short_enable", 16'(oDecEnable), 16'd0);
    chk("short_decreset", 16'(oDecReset), 16'd1);
    chk("short_no_done", 16'(oFrameDone), 16'd0);
    tick();
    chk("short_sticky", 16'(oError), 16'd1);
    chk("short_no_done2", 16'(oFrameDone), 16'd0);

    // Watchdog: restart from ERROR, decoder silent for 16 enabled cycles
    enter_run(16'd4, 3'd0);
    repeat (15) tick();
    chk("wd_15_no_error", 16'(oError), 16'd0);
    chk("wd_15_enable", 16'(oDecEnable), 16'd1);
    tick();
    chk("wd_16_error", 16'(oError), 16'd1);
    chk("wd_16_code", 16'(oErrorCode), 16'd2);
    chk("wd_16_enable", 16'(oDecEnable), 16'd0);

    // Restart after watchdog runs normally
    enter_run(16'd2, 3'd0);
    send(16'd7, 3'd0, 16'd0);
    send(16'd8, 3'd0, 16'd1);
    tick();
    chk("wd_restart_done", 16'(oFrameDone), 16'd1);
    chk("wd_restart_no_error", 16'(oError), 16'd0);
    tick();

    // Zero block size
    iBlockSize  = 16'd0;
    iFrameStart = 1'b1;
    tick();
    iFrameStart = 1'b0;
    chk("zero_error", 16'(oError), 16'd1);
    chk("zero_code", 16'(oErrorCode), 16'd3);
    chk("zero_busy", 16'(oBusy), 16'd1);
    chk("zero_decreset", 16'(oDecReset), 16'd1);
    tick();
    chk("zero_no_done", 16'(oFrameDone), 16'd0);

    // Reset mid-run on channel 1 at sample 2
    enter_run(16'd4, 3'd1);
    for (int i = 0; i < 4; i++) send(16'(i), 3'd0, 16'(i));
    tick();
    tick();
    tick();
    chk("mr_ch1_enable", 16'(oDecEnable), 16'd1);
    send(16'd50, 3'd1, 16'd0);
    send(16'd51, 3'd1, 16'd1);
    iReset          = 1'b1;
    iDecSampleValid = 1'b1;
    iDecSample      = 16'd777;
    tick();
    iReset          = 1'b0;
    iDecSampleValid = 1'b0;
    chk("mr_valid", 16'(oSampleValid), 16'd0);
    chk("mr_sample", oSample, 16'd0);
    chk("mr_channel", 16'(oChannel), 16'd0);
    chk("mr_index", oSampleIndex, 16'd0);
    chk("mr_busy", 16'(oBusy), 16'd0);
    chk("mr_decreset", 16'(oDecReset), 16'd1);
    chk("mr_enable", 16'(oDecEnable), 16'd0);
    chk("mr_blocksize", oDecBlockSize, 16'd0);
    chk("mr_error", 16'(oError), 16'd0);
    chk("mr_code", 16'(oErrorCode), 16'd0);
    chk("mr_done", 16'(oFrameDone), 16'd0);
    tick();
    chk("mr_done_later", 16'(oFrameDone), 16'd0);
    enter_run(16'd1, 3'd0);
    send(16'd5, 3'd0, 16'd0);
    tick();
    chk("mr_new_frame_done", 16'(oFrameDone), 16'd1);
    tick();
    chk("mr_new_frame_idle", 16'(oBusy), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
